result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each digit is held active; legal range 2..65535.
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low.
REQ-004 LD  input  1  capture strobe; Din SHALL be sampled on every rising edge where LD=1.
REQ-005 Din  input  16  result word from the datapath ALU output.
REQ-006 BLANK_LZ  input  1  leading-zero blanking enable.
REQ-007 LD_ACK  output  1  one-cycle pulse acknowledging a capture.
REQ-008 FRAME  output  1  one-cycle pulse at completion of each 4-digit scan.
REQ-009 AN  output  4  digit anodes, active-low; AN[k] drives hex digit k, where k=0 is the least significant.
REQ-010 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 Capture: when LD=1, shadow register SHALL load Din, and LD_ACK SHALL be 1 in the following cycle only.
- LD held high: shadow SHALL reload every cycle, and LD_ACK SHALL stay high one cycle after each LD cycle.
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
- Terminal count (TC) = counter at REFRESH_DIV-1.
REQ-013 Digit index (2 bits, reset 0) SHALL advance on each TC cycle: 0->1->2->3->0.
REQ-014 FRAME SHALL pulse 1 in the cycle after a TC where index wraps 3->0.
REQ-015 Display register SHALL load from shadow on the index 3->0 wrap, so a value never changes mid-scan.
- If LD=1 in that same cycle, display SHALL load Din directly, and shadow SHALL also load Din.
REQ-016 AN and SEG SHALL be registered outputs derived from the current index and display register, with one-cycle latency from the index change.
REQ-017 AN SHALL drive exactly one bit low (bit = index) unless that digit is blanked; blanked digits SHALL give AN=4'b1111 and SEG=7'b1111111.
REQ-018 With BLANK_LZ=1, digit k (k>=1) SHALL be blanked when it and every higher digit of the display register are zero; digit 0 SHALL never be blanked.
- With BLANK_LZ=0, no digit SHALL be blanked.
- BLANK_LZ SHALL act on the next output update with no frame alignment.
REQ-019 Hex decode SHALL be (active-low {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110

Reset
REQ-020 While RST_N=0 at a clock edge, the block SHALL reset to:
- counter=0, index=0, shadow=0, display=0
- LD_ACK=0, FRAME=0, AN=4'b1111, SEG=7'b1111111
REQ-021 Reset SHALL override LD; a capture coincident with reset SHALL be discarded, with no LD_ACK.
REQ-022 Reset asserted mid-scan SHALL restart the scan at digit 0 with counter 0.
- First post-reset output (cycle after release) SHALL be AN=4'b1110, SEG=7'b1000000.

Verification (REFRESH_DIV=4)
REQ-023 Reset release -> AN=1110, SEG=1000000 one cycle later; AN steps 1101, 1011, 0111 every 4 cycles; FRAME pulses once per 16 cycles.
REQ-024 LD=1, Din=16'h12AF mid-frame -> LD_ACK pulse next cycle; digits stay 0 until wrap; next frame shows F, A, 2, 1 (SEG 0001110, 0001000, 0100100, 1111001).
REQ-025 Din=16'h0005, BLANK_LZ=1 -> only digit 0 lit (SEG 0010010); digits 1-3 AN=1111; with BLANK_LZ=0 digits 1-3 show 1000000.
REQ-026 Din=16'h0000, BLANK_LZ=1 -> digit 0 shows 0; digits 1-3 blank.
REQ-027 LD=1, Din=16'hBEEF in the exact 3->0 wrap cycle -> the frame starting then shows F, E, E, b with no frame of stale data.
REQ-028 RST_N=0 for one cycle during digit 2 with LD=1 -> LD_ACK stays 0, display=0, and scan restarts at digit 0.

Source files
------------

// File: rtl/result_display.sv
// Four-digit multiplexed hex display driver for a 16-bit result word.
// Captured values are double-buffered so a frame never shows a mix of old and new digits.
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LD,
    input  logic [15:0] Din,
    input  logic        BLANK_LZ,
    output logic        LD_ACK,
    output logic        FRAME,
    output logic [3:0]  AN,
    output logic [6:0]  SEG
);

    localparam logic [15:0] TC_VAL = 16'(REFRESH_DIV - 1);

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_shadow;
    logic [15:0] r_disp;
    logic        r_ack;
    logic        r_frame;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;

    logic        w_tc;
    logic        w_wrap;
    logic [3:0]  w_blank;
    logic [3:0]  w_nib;
    logic [6:0]  w_dec;
    logic [3:0]  w_an_next;
    logic [6:0]  w_seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_tc   = (r_cnt == TC_VAL);
    assign w_wrap = w_tc && (r_idx == 2'd3);

    // A digit is a leading zero when it and every more significant nibble are zero.
    assign w_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign w_blank[gi] = BLANK_LZ && (r_disp[15:4*gi] == '0);
        end
    endgenerate

    assign w_nib = r_disp[4*r_idx +: 4];
    assign w_dec = hex7(w_nib);

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = 7'b1111111;
        if (!w_blank[r_idx]) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_dec;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_ack    <= 1'b0;
            r_frame  <= 1'b0;
            r_an     <= 4'b1111;
            r_seg    <= 7'b1111111;
        end else begin
            r_cnt   <= w_tc ? '0 : r_cnt + 16'd1;
            r_ack   <= LD;
            r_frame <= w_wrap;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
            if (w_tc)
                r_idx <= r_idx + 2'd1;
            if (LD)
                r_shadow <= Din;
            // A capture landing on the wrap edge goes straight to the display.
            if (w_wrap)
                r_disp <= LD ? Din : r_shadow;
        end
    end

    assign LD_ACK = r_ack;
    assign FRAME  = r_frame;
    assign AN     = r_an;
    assign SEG    = r_seg;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with REFRESH_DIV=4 (one digit per 4 cycles, 16-cycle frame).
module tb_result_display;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LD;
    logic [15:0] Din;
    logic        BLANK_LZ;
    logic        LD_ACK;
    logic        FRAME;
    logic [3:0]  AN;
    logic [6:0]  SEG;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b0000011;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_F = 7'b0001110;

    result_display #(.REFRESH_DIV(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .LD(LD), .Din(Din), .BLANK_LZ(BLANK_LZ),
        .LD_ACK(LD_ACK), .FRAME(FRAME), .AN(AN), .SEG(SEG)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset;
        RST_N = 1'b0; LD = 1'b1; Din = 16'hFFFF; BLANK_LZ = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (LD_ACK !== 1'b0 || FRAME !== 1'b0 || AN !== 4'b1111 || SEG !== S_OFF) begin
                errors++;
                $display("FAIL reset ack=%b frame=%b an=%b seg=%b exp 0 0 1111 1111111", LD_ACK, FRAME, AN, SEG);
            end
        end
        RST_N = 1'b1; LD = 1'b0;
        cyc = 0;
        $display("test_reset done");
    endtask

    task automatic test_scan;
        int d;
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        repeat (32) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== exp_an[d] || SEG !== S_0 || FRAME !== (cyc % 16 == 0)) begin
                errors++;
                $display("FAIL scan cyc=%0d an=%b seg=%b frame=%b exp an=%b seg=%b frame=%b",
                         cyc, AN, SEG, FRAME, exp_an[d], S_0, (cyc % 16 == 0));
            end
        end
        $display("test_scan done");
    endtask

    task automatic test_capture;
        int d;
        step_to(37);
        LD = 1'b1; Din = 16'h12AF;
        step();
        LD = 1'b0;
        checks++;
        if (LD_ACK !== 1'b1) begin errors++; $display("FAIL cap_ack got=%b exp=1", LD_ACK); end
        step();
        checks++;
        if (LD_ACK !== 1'b0) begin errors++; $display("FAIL cap_ack_end got=%b exp=0", LD_ACK); end
        while (cyc < 48) begin
            step();
            checks++;
            if (SEG !== S_0) begin errors++; $display("FAIL cap_stale cyc=%0d seg=%b exp=%b", cyc, SEG, S_0); end
        end
        exp_seg = '{S_F, S_A, S_2, S_1};
        repeat (16) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== exp_an[d] || SEG !== exp_seg[d] || FRAME !== (cyc % 16 == 0)) begin
                errors++;
                $display("FAIL cap_frame cyc=%0d an=%b seg=%b frame=%b exp an=%b seg=%b", cyc, AN, SEG, FRAME, exp_an[d], exp_seg[d]);
            end
        end
        $display("test_capture done");
    endtask

    task automatic test_back_to_back;
        int d;
        logic [3:0]  an_b[4];
        step_to(66);
        BLANK_LZ = 1'b1; LD = 1'b1; Din = 16'h1111;
        step();
        Din = 16'h2222;
        checks++;
        if (LD_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", LD_ACK); end
        step();
        Din = 16'h0005;
        checks++;
        if (LD_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got=%b exp=1", LD_ACK); end
        step();
        LD = 1'b0;
        checks++;
        if (LD_ACK !== 1'b1) begin errors++; $display("FAIL b2b_ack3 got=%b exp=1", LD_ACK); end
        step();
        checks++;
        if (LD_ACK !== 1'b0) begin errors++; $display("FAIL b2b_ack_end got=%b exp=0", LD_ACK); end
        step_to(80);
        an_b = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        exp_seg = '{S_5, S_OFF, S_OFF, S_OFF};
        repeat (16) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== an_b[d] || SEG !== exp_seg[d]) begin
                errors++;
                $display("FAIL blank5 cyc=%0d an=%b seg=%b exp an=%b seg=%b", cyc, AN, SEG, an_b[d], exp_seg[d]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_blank_off;
        int d;
        BLANK_LZ = 1'b0;
        exp_seg = '{S_5, S_0, S_0, S_0};
        repeat (16) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== exp_an[d] || SEG !== exp_seg[d]) begin
                errors++;
                $display("FAIL noblank cyc=%0d an=%b seg=%b exp an=%b seg=%b", cyc, AN, SEG, exp_an[d], exp_seg[d]);
            end
            if (cyc == 97) begin LD = 1'b1; Din = 16'h0000; end
            else LD = 1'b0;
        end
        $display("test_blank_off done");
    endtask

    task automatic test_zero;
        int d;
        logic [3:0] an_b[4];
        BLANK_LZ = 1'b1;
        an_b = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        exp_seg = '{S_0, S_OFF, S_OFF, S_OFF};
        repeat (16) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== an_b[d] || SEG !== exp_seg[d]) begin
                errors++;
                $display("FAIL zero cyc=%0d an=%b seg=%b exp an=%b seg=%b", cyc, AN, SEG, an_b[d], exp_seg[d]);
            end
            if (cyc == 127) begin LD = 1'b1; Din = 16'hBEEF; end
            else LD = 1'b0;
        end
        $display("test_zero done");
    endtask

    task automatic test_wrap_load;
        int d;
        checks++;
        if (LD_ACK !== 1'b1) begin errors++; $display("FAIL wrap_ack got=%b exp=1", LD_ACK); end
        exp_seg = '{S_F, S_E, S_E, S_B};
        repeat (16) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== exp_an[d] || SEG !== exp_seg[d]) begin
                errors++;
                $display("FAIL wrap_frame cyc=%0d an=%b seg=%b exp an=%b seg=%b", cyc, AN, SEG, exp_an[d], exp_seg[d]);
            end
        end
        $display("test_wrap_load done");
    endtask

    task automatic test_reset_mid;
        int d;
        step_to(154);
        RST_N = 1'b0; LD = 1'b1; Din = 16'h1234;
        step();
        checks++;
        if (LD_ACK !== 1'b0 || FRAME !== 1'b0 || AN !== 4'b1111 || SEG !== S_OFF) begin
            errors++;
            $display("FAIL midrst ack=%b frame=%b an=%b seg=%b exp 0 0 1111 1111111", LD_ACK, FRAME, AN, SEG);
        end
        RST_N = 1'b1; LD = 1'b0; BLANK_LZ = 1'b0;
        cyc = 0;
        repeat (32) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (AN !== exp_an[d] || SEG !== S_0 || FRAME !== (cyc % 16 == 0) || LD_ACK !== 1'b0) begin
                errors++;
                $display("FAIL midrst_scan cyc=%0d an=%b seg=%b frame=%b ack=%b exp an=%b seg=%b frame=%b ack=0",
                         cyc, AN, SEG, FRAME, LD_ACK, exp_an[d], S_0, (cyc % 16 == 0));
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        RST_N = 1'b0; LD = 1'b0; Din = '0; BLANK_LZ = 1'b0;
        test_reset();
        test_scan();
        test_capture();
        test_back_to_back();
        test_blank_off();
        test_zero();
        test_wrap_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
